// File: rtl/band_gain_pkg.sv
// Shared constants, band tables, FSM state type and arithmetic helpers
// for the band gain application block (band_gain_apply / gain_interp).
package band_gain_pkg;

    localparam int NB_BANDS  = 22;
    localparam int FREQ_SIZE = 481;
    localparam int GAIN_W    = 16;
    localparam int BIN_W     = 24;

    localparam logic [GAIN_W-1:0] GAIN_ONE = 16'h8000;
    localparam logic [15:0]       SMOOTH_K = 16'd19661;

    typedef enum logic {LOAD, RUN} state_t;

    // Band edges in units of 4 bins.
    localparam int EBAND [NB_BANDS] = '{
        0, 1, 2, 3, 4, 5, 6, 7, 8, 10, 12,
        14, 16, 20, 24, 28, 34, 40, 48, 60, 78, 100
    };

    // round(65536 / band width in bins).
    localparam int RECIP [NB_BANDS-1] = '{
        16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384,
        8192, 8192, 8192, 8192,
        4096, 4096, 4096,
        2731, 2731, 2048, 1365, 910, 745
    };

    // Width-minus-one of band b in bins; 0 for the terminal band.
    function automatic logic [6:0] band_wm1(input logic [4:0] b);
        int i;
        i = int'(b);
        if (i >= NB_BANDS - 1) return 7'd0;
        return 7'(((EBAND[i+1] - EBAND[i]) << 2) - 1);
    endfunction

    // Q1.15 gain applied with half-up rounding and saturation.
    function automatic logic signed [BIN_W-1:0] apply_gain(
        input logic signed [BIN_W-1:0] x,
        input logic [GAIN_W-1:0]       g
    );
        logic signed [41:0] p;
        logic signed [26:0] r;
        p = x * $signed({1'b0, g}) + 42'sd16384;
        r = 27'(p >>> 15);
        if (r > 27'sd8388607)       return 24'sh7FFFFF;
        else if (r < -27'sd8388608) return 24'sh800000;
        else                        return r[BIN_W-1:0];
    endfunction

endpackage

// File: rtl/gain_interp.sv
// Linear interpolation between two adjacent band gains; registered
// output forms pipeline stage 1. Ports: clk, rst, en, g_lo, g_hi, j, recip -> g_k.
module gain_interp
    import band_gain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [GAIN_W-1:0] g_lo,
    input  logic [GAIN_W-1:0] g_hi,
    input  logic [6:0]        j,
    input  logic [14:0]       recip,
    output logic [GAIN_W-1:0] g_k
);

    logic signed [16:0] diff;
    logic signed [39:0] prod;
    logic signed [23:0] step;
    logic signed [24:0] sum;

    assign diff = $signed({1'b0, g_hi}) - $signed({1'b0, g_lo});
    assign prod = $signed({1'b0, j}) * diff * $signed({1'b0, recip});
    assign step = 24'(prod >>> 16);
    assign sum  = $signed({9'b0, g_lo}) + 25'(step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_k <= '0;
        end else if (en) begin
            // Rounded reciprocal can overshoot by a hair; keep within Q1.15 range.
            if (sum < 25'sd0)            g_k <= '0;
            else if (sum > 25'sd32768)   g_k <= GAIN_ONE;
            else                         g_k <= sum[GAIN_W-1:0];
        end
    end

endmodule

// File: rtl/band_gain_apply.sv
// Loads NB_BANDS band gains, interpolates them per bin and scales the
// spectrum. Ports: gain_* (valid/ready in), bin_in_* (valid/ready in),
// bin_out_* (valid/ready out, last), frame_done pulse.
// Optional: define LASTG_SMOOTH_EN to limit frame-to-frame gain decay.
module band_gain_apply
    import band_gain_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gain_valid,
    output logic                    gain_ready,
    input  logic [GAIN_W-1:0]       gain_data,
    input  logic                    bin_in_valid,
    output logic                    bin_in_ready,
    input  logic signed [BIN_W-1:0] bin_in_re,
    input  logic signed [BIN_W-1:0] bin_in_im,
    output logic                    bin_out_valid,
    input  logic                    bin_out_ready,
    output logic signed [BIN_W-1:0] bin_out_re,
    output logic signed [BIN_W-1:0] bin_out_im,
    output logic                    bin_out_last,
    output logic                    frame_done
);

    state_t state_q, state_d;

    logic [4:0]        band_cnt;
    logic [8:0]        bin_cnt;
    logic [4:0]        band_q;
    logic [6:0]        j_q;
    logic              in_done;
    logic [GAIN_W-1:0] gbuf [NB_BANDS];

    logic              gain_fire, in_fire, out_fire, last_fire, advance;
    logic [GAIN_W-1:0] g_clamp, g_eff;
    logic [GAIN_W-1:0] g_lo, g_hi, g_k;
    logic [14:0]       recip;

    logic                    s1_valid, s1_last;
    logic signed [BIN_W-1:0] s1_re, s1_im;

    assign advance   = !bin_out_valid || bin_out_ready;
    assign gain_fire = gain_valid && (state_q == LOAD);
    assign in_fire   = bin_in_valid && bin_in_ready;
    assign out_fire  = bin_out_valid && bin_out_ready;
    assign last_fire = out_fire && bin_out_last;

    assign g_clamp = (gain_data > GAIN_ONE) ? GAIN_ONE : gain_data;

`ifdef LASTG_SMOOTH_EN
    logic [GAIN_W-1:0] lastg [NB_BANDS];
    logic [GAIN_W-1:0] decayed;

    assign decayed = GAIN_W'((32'(lastg[band_cnt]) * 32'(SMOOTH_K)) >> 15);
    assign g_eff   = (g_clamp > decayed) ? g_clamp : decayed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_BANDS; i++) lastg[i] <= '0;
        end else if (gain_fire) begin
            lastg[band_cnt] <= g_eff;
        end
    end
`else
    assign g_eff = g_clamp;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        gain_ready   = 1'b0;
        bin_in_ready = 1'b0;
        unique case (state_q)
            LOAD: begin
                gain_ready = 1'b1;
                if (gain_fire && band_cnt == 5'(NB_BANDS-1)) state_d = RUN;
            end
            RUN: begin
                bin_in_ready = !in_done && advance;
                if (last_fire) state_d = LOAD;
            end
        endcase
    end

    // Bins past the last band edge see both ends at zero, so g_k = 0.
    always_comb begin
        g_lo  = '0;
        g_hi  = '0;
        recip = '0;
        if (band_q < 5'(NB_BANDS-1)) begin
            g_lo  = gbuf[band_q];
            g_hi  = gbuf[band_q + 5'd1];
            recip = 15'(RECIP[band_q]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_cnt <= '0;
            bin_cnt  <= '0;
            band_q   <= '0;
            j_q      <= '0;
            in_done  <= 1'b0;
            for (int i = 0; i < NB_BANDS; i++) gbuf[i] <= '0;
        end else begin
            if (gain_fire) begin
                gbuf[band_cnt] <= g_eff;
                band_cnt <= (band_cnt == 5'(NB_BANDS-1)) ? '0 : band_cnt + 5'd1;
            end
            if (in_fire) begin
                bin_cnt <= bin_cnt + 9'd1;
                if (bin_cnt == 9'(FREQ_SIZE-1)) in_done <= 1'b1;
                if (band_q < 5'(NB_BANDS-1)) begin
                    if (j_q == band_wm1(band_q)) begin
                        band_q <= band_q + 5'd1;
                        j_q    <= '0;
                    end else begin
                        j_q <= j_q + 7'd1;
                    end
                end
            end
            if (last_fire) begin
                bin_cnt <= '0;
                in_done <= 1'b0;
                band_q  <= '0;
                j_q     <= '0;
            end
        end
    end

    gain_interp u_interp (
        .clk   (clk),
        .rst   (rst),
        .en    (advance),
        .g_lo  (g_lo),
        .g_hi  (g_hi),
        .j     (j_q),
        .recip (recip),
        .g_k   (g_k)
    );

    // Whole pipeline moves together whenever the output slot frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_re         <= '0;
            s1_im         <= '0;
            bin_out_valid <= 1'b0;
            bin_out_re    <= '0;
            bin_out_im    <= '0;
            bin_out_last  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= last_fire;
            if (advance) begin
                s1_valid      <= in_fire;
                s1_last       <= in_fire && (bin_cnt == 9'(FREQ_SIZE-1));
                s1_re         <= bin_in_re;
                s1_im         <= bin_in_im;
                bin_out_valid <= s1_valid;
                bin_out_last  <= s1_valid && s1_last;
                if (s1_valid) begin
                    bin_out_re <= apply_gain(s1_re, g_k);
                    bin_out_im <= apply_gain(s1_im, g_k);
                end
            end
        end
    end

endmodule
